// File: rtl/aes_pkg.sv
// Shared widths for the AES result path and the word-select helper used by the serializer.
package aes_pkg;

  localparam int AES_BLOCK_W         = 128;
  localparam int AES_WORD_W          = 32;
  localparam int AES_WORDS_PER_BLOCK = 4;

  // Word idx of blk in send order; msw_first picks [127:96] as word 0, else [31:0].
  function automatic logic [AES_WORD_W-1:0] blk_word(
    input logic [AES_BLOCK_W-1:0] blk,
    input logic [1:0]             idx,
    input logic                   msw_first
  );
    logic [1:0] slot;
    slot = msw_first ? ~idx : idx;
    return blk[{slot, 5'b0} +: AES_WORD_W];
  endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Generic width/depth FIFO with registered full/empty flags; head reads as zero when empty.
module aes_blk_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // When full, a push lands on the slot being popped in the same cycle, which is safe.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = empty_q ? '0 : mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/aes_out_serializer.sv
// Buffers 128-bit AES results and streams each out as four 32-bit words over valid/ready.
module aes_out_serializer
  import aes_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter bit MSW_FIRST = 1
) (
  input  logic                   AES_clk,
  input  logic                   AES_rst_n,
  input  logic                   AES_data_out_valid,
  input  logic [AES_BLOCK_W-1:0] AES_data_out,
  input  logic                   ser_ready,
  output logic                   ser_valid,
  output logic [AES_WORD_W-1:0]  ser_data,
  output logic                   ser_last,
  output logic                   fifo_full,
  output logic [7:0]             overflow_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [AES_BLOCK_W-1:0] head_blk;
  logic                   fifo_empty;
  logic [CW-1:0]          fifo_cnt;
  logic                   xfer, push, pop, drop;
  logic [1:0]             word_idx_q, word_idx_d;
  logic [7:0]             ovf_q, ovf_d;

  aes_blk_fifo #(
    .W     (AES_BLOCK_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (AES_clk),
    .rst_n (AES_rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (AES_data_out),
    .rdata (head_blk),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // A full FIFO still accepts when the head's last word leaves this cycle.
  always_comb begin
    xfer = ser_valid && ser_ready;
    pop  = xfer && (word_idx_q == 2'd3);
    push = AES_data_out_valid && ((fifo_cnt < CW'(DEPTH)) || pop);
    drop = AES_data_out_valid && !push;

    word_idx_d = xfer ? word_idx_q + 2'd1 : word_idx_q;
    ovf_d      = (drop && (ovf_q != 8'hFF)) ? ovf_q + 8'd1 : ovf_q;
  end

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      word_idx_q <= 2'd0;
      ovf_q      <= 8'd0;
    end else begin
      word_idx_q <= word_idx_d;
      ovf_q      <= ovf_d;
    end
  end

  assign ser_valid    = !fifo_empty;
  assign ser_data     = blk_word(head_blk, word_idx_q, MSW_FIRST);
  assign ser_last     = ser_valid && (word_idx_q == 2'd3);
  assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_aes_out_serializer.sv
// Scoreboard bench: stimulus queues hand-computed words, negedge monitors compare presented words.
module tb_aes_out_serializer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         vld, vld0;
  logic [127:0] din, din0;
  logic         rdy, rdy0;

  logic         sv, sl, ff;
  logic [31:0]  sd;
  logic [7:0]   ovf;
  logic         sv0, sl0, ff0;
  logic [31:0]  sd0;
  logic [7:0]   ovf0;

  int tests = 0;
  int fails = 0;
  int xfers = 0;
  int xfers0 = 0;
  logic [32:0] exp_q[$];
  logic [32:0] exp0_q[$];

  always #5 clk = ~clk;

  aes_out_serializer #(.DEPTH(2), .MSW_FIRST(1)) dut (
    .AES_clk            (clk),
    .AES_rst_n          (rst_n),
    .AES_data_out_valid (vld),
    .AES_data_out       (din),
    .ser_ready          (rdy),
    .ser_valid          (sv),
    .ser_data           (sd),
    .ser_last           (sl),
    .fifo_full          (ff),
    .overflow_cnt       (ovf)
  );

  aes_out_serializer #(.DEPTH(2), .MSW_FIRST(0)) dut0 (
    .AES_clk            (clk),
    .AES_rst_n          (rst_n),
    .AES_data_out_valid (vld0),
    .AES_data_out       (din0),
    .ser_ready          (rdy0),
    .ser_valid          (sv0),
    .ser_data           (sd0),
    .ser_last           (sl0),
    .fifo_full          (ff0),
    .overflow_cnt       (ovf0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Head of queue is compared every presented cycle, so stalls also prove the word holds.
  always @(negedge clk) begin
    if (rst_n && sv) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL mon_extra: got word %h last %b with nothing expected", sd, sl);
      end else begin
        if ({sl, sd} !== exp_q[0]) begin
          fails++;
          $display("FAIL mon_word: got last=%b data=%h expected last=%b data=%h",
                   sl, sd, exp_q[0][32], exp_q[0][31:0]);
        end
        if (rdy) begin
          void'(exp_q.pop_front());
          xfers++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && sv0) begin
      tests++;
      if (exp0_q.size() == 0) begin
        fails++;
        $display("FAIL mon0_extra: got word %h last %b with nothing expected", sd0, sl0);
      end else begin
        if ({sl0, sd0} !== exp0_q[0]) begin
          fails++;
          $display("FAIL mon0_word: got last=%b data=%h expected last=%b data=%h",
                   sl0, sd0, exp0_q[0][32], exp0_q[0][31:0]);
        end
        if (rdy0) begin
          void'(exp0_q.pop_front());
          xfers0++;
        end
      end
    end
  end

  task automatic exp_words(input bit which, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
    if (!which) begin
      exp_q.push_back({1'b0, w0});
      exp_q.push_back({1'b0, w1});
      exp_q.push_back({1'b0, w2});
      exp_q.push_back({1'b1, w3});
    end else begin
      exp0_q.push_back({1'b0, w0});
      exp0_q.push_back({1'b0, w1});
      exp0_q.push_back({1'b0, w2});
      exp0_q.push_back({1'b1, w3});
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [127:0] b);
    vld = 1'b1;
    din = b;
    step(1);
    vld = 1'b0;
    din = '0;
  endtask

  task automatic strobe0(input logic [127:0] b);
    vld0 = 1'b1;
    din0 = b;
    step(1);
    vld0 = 1'b0;
    din0 = '0;
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    vld = 1'b0; din = '0; rdy = 1'b0;
    vld0 = 1'b0; din0 = '0; rdy0 = 1'b0;
    #12;
    check("rst_valid", 32'(sv), 32'd0);
    check("rst_last", 32'(sl), 32'd0);
    check("rst_full", 32'(ff), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_data", sd, 32'd0);
    check("rst_data0", sd0, 32'd0);
    rst_n = 1'b1;
    step(1);
    check("idle_valid", 32'(sv), 32'd0);

    // Single block, ready held high: four consecutive words then idle.
    rdy = 1'b1;
    exp_words(0, 32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a);
    strobe(128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_valid_run", 32'(sv), 32'd1);
    end
    @(negedge clk);
    check("t1_valid_after", 32'(sv), 32'd0);
    check("t1_drained", 32'(exp_q.size()), 32'd0);
    step(1);

    // Backpressure pattern 1,0,0,1,...: exactly four transfers.
    base = xfers;
    exp_words(0, 32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a);
    strobe(128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a);
    for (int c = 0; c < 14; c++) begin
      rdy = (c % 3 == 0);
      step(1);
    end
    check("t2_xfers", 32'(xfers - base), 32'd4);
    check("t2_valid_after", 32'(sv), 32'd0);

    // Overflow: A and B fill the FIFO, C is dropped.
    rdy = 1'b0;
    exp_words(0, 32'ha0000001, 32'ha0000002, 32'ha0000003, 32'ha0000004);
    exp_words(0, 32'hb0000001, 32'hb0000002, 32'hb0000003, 32'hb0000004);
    strobe(128'ha0000001_a0000002_a0000003_a0000004);
    check("t3_full_after_a", 32'(ff), 32'd0);
    strobe(128'hb0000001_b0000002_b0000003_b0000004);
    check("t3_full_after_b", 32'(ff), 32'd1);
    check("t3_ovf_before_c", 32'(ovf), 32'd0);
    strobe(128'hc0000001_c0000002_c0000003_c0000004);
    check("t3_ovf_after_c", 32'(ovf), 32'd1);
    check("t3_full_after_c", 32'(ff), 32'd1);
    rdy = 1'b1;
    step(8);
    check("t3_valid_drained", 32'(sv), 32'd0);
    check("t3_full_drained", 32'(ff), 32'd0);
    check("t3_queue_drained", 32'(exp_q.size()), 32'd0);
    check("t3_ovf_hold", 32'(ovf), 32'd1);

    // Saturation: fill G,H then 256 back-to-back dropped strobes.
    rdy = 1'b0;
    exp_words(0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    exp_words(0, 32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888);
    strobe(128'h11111111_22222222_33333333_44444444);
    strobe(128'h55555555_66666666_77777777_88888888);
    vld = 1'b1;
    din = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
    step(256);
    vld = 1'b0;
    din = '0;
    check("t3b_ovf_sat", 32'(ovf), 32'd255);

    // Full FIFO, head on word 3 transferring while D arrives: D accepted.
    rdy = 1'b1;
    step(3);
    check("t4_last_on_w3", 32'(sl), 32'd1);
    exp_words(0, 32'hd0000001, 32'hd0000002, 32'hd0000003, 32'hd0000004);
    strobe(128'hd0000001_d0000002_d0000003_d0000004);
    check("t4_ovf_unchanged", 32'(ovf), 32'd255);
    check("t4_full_stays", 32'(ff), 32'd1);
    step(8);
    check("t4_valid_drained", 32'(sv), 32'd0);
    check("t4_queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset after word 1 of E; next block F starts at word 0.
    exp_q.push_back({1'b0, 32'he0000001});
    exp_q.push_back({1'b0, 32'he0000002});
    strobe(128'he0000001_e0000002_e0000003_e0000004);
    step(2);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(sv), 32'd0);
    check("t5_rst_last", 32'(sl), 32'd0);
    check("t5_rst_ovf", 32'(ovf), 32'd0);
    check("t5_rst_full", 32'(ff), 32'd0);
    check("t5_rst_data", sd, 32'd0);
    check("t5_queue_at_rst", 32'(exp_q.size()), 32'd0);
    #2;
    rst_n = 1'b1;
    step(1);
    exp_words(0, 32'hf0000001, 32'hf0000002, 32'hf0000003, 32'hf0000004);
    strobe(128'hf0000001_f0000002_f0000003_f0000004);
    step(5);
    check("t5_valid_after", 32'(sv), 32'd0);
    check("t5_queue_drained", 32'(exp_q.size()), 32'd0);

    // LSW-first instance.
    rdy0 = 1'b1;
    base = xfers0;
    exp_words(1, 32'h00000000, 32'h00000001, 32'h00000002, 32'h00000003);
    strobe0(128'h00000003_00000002_00000001_00000000);
    step(5);
    check("t6_xfers", 32'(xfers0 - base), 32'd4);
    check("t6_valid_after", 32'(sv0), 32'd0);
    check("t6_queue_drained", 32'(exp0_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
